// File: rtl/handshake_rr_mux.sv
// N-channel handshake concentrator: per-channel one-entry buffers drained onto one sink bus.
// Optional build macro HANDSHAKE_RR_MUX_FIXED_PRIO_EN swaps round-robin for fixed priority.
module handshake_rr_mux #(
    parameter int WIDTH = 8,
    parameter int CH = 4,
    localparam int CH_W = $clog2(CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CH-1:0]         sready,
    input  logic [CH*WIDTH-1:0]   din,
    output logic [CH-1:0]         sidle,
    output logic [CH-1:0]         ovf,
    input  logic                  dbusy,
    output logic                  dvalid,
    output logic [WIDTH-1:0]      dout,
    output logic [CH_W-1:0]       dch
);

    logic [CH-1:0]    full;
    logic [WIDTH-1:0] data_q [CH];
    logic             grant_vld;
    logic [CH_W-1:0]  grant_idx;

    assign sidle = ~full;

`ifdef HANDSHAKE_RR_MUX_FIXED_PRIO_EN
    // Descending scan: the last hit, the lowest-index full channel, wins.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        grant_vld = 1'b0;
        grant_idx = '0;
        if (!dbusy) begin
            for (int k = CH - 1; k >= 0; k--) begin
                if (full[k]) begin
                    grant_vld = 1'b1;
                    grant_idx = CH_W'(k);
                end
            end
        end
    end
`else
    logic [CH_W-1:0] ptr;

    function automatic logic [CH_W-1:0] rr_idx(input logic [CH_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= CH) sum = sum - CH;
        return CH_W'(sum);
    endfunction

    // Descending offset scan: the last hit is the nearest full channel at or after ptr.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        grant_vld = 1'b0;
        grant_idx = '0;
        if (!dbusy) begin
            for (int k = CH - 1; k >= 0; k--) begin
                if (full[rr_idx(ptr, k)]) begin
                    grant_vld = 1'b1;
                    grant_idx = rr_idx(ptr, k);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (grant_vld) begin
            ptr <= rr_idx(grant_idx, 1);
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full   <= '0;
            ovf    <= '0;
            dvalid <= 1'b0;
            dout   <= '0;
            dch    <= '0;
            // NOTE: buffers are cleared as well so the post-reset state is fully deterministic.
            for (int i = 0; i < CH; i++) data_q[i] <= '0;
        end else begin
            // A write landing on the channel being granted refills it; anything else into a full buffer is dropped.
            for (int i = 0; i < CH; i++) begin
                if (sready[i] && (!full[i] || (grant_vld && grant_idx == CH_W'(i)))) begin
                    data_q[i] <= din[i*WIDTH +: WIDTH];
                    full[i]   <= 1'b1;
                end else if (grant_vld && grant_idx == CH_W'(i)) begin
                    full[i]   <= 1'b0;
                end
                ovf[i] <= sready[i] && full[i] && !(grant_vld && grant_idx == CH_W'(i));
            end
            dvalid <= grant_vld;
            dout   <= grant_vld ? data_q[grant_idx] : '0;
            dch    <= grant_vld ? grant_idx : '0;
        end
    end

endmodule
